control_unit: RTL and testbench

//  Multi-cycle sequencer and instruction decoder for the RV32I core: fetches an instruction, decodes it
//  and drives the ALU operation code, operand selects, register-file and PC controls.

---
 rtl/alu_operations_pkg.sv | 17 +
 rtl/control_unit_pkg.sv | 34 +++
 rtl/control_unit_immediate_generator.sv | 22 ++
 rtl/control_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_operations_pkg.sv
// ALU operation codes shared by the control unit and the ALU.
package alu_operations;

   typedef enum logic [3:0] {
      Add,
      Subtract,
      Shift_Left_Logical,
      Set_Less_Than,
      Set_Less_Than_Unsigned,
      Xor,
      Shift_Right_Logical,
      Shift_Right_Arithmetic,
      Or,
      And
   } alu_operation_t;

endpackage

// File: rtl/control_unit_pkg.sv
// Sequencer states, datapath select encodings and RV32I opcode constants.
package control_unit_types;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} src_1_sel_t;
   typedef enum logic       {SRC2_RS2, SRC2_IMM} src_2_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC_PLUS_4} wb_sel_t;
   typedef enum logic [1:0] {PC_PLUS_4, PC_IMM, PC_ALU_ALIGNED} pc_sel_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/control_unit_immediate_generator.sv
// Extracts and sign-extends the I/S/B/U/J immediate of an instruction word.
module immediate_generator
   import control_unit_types::*;
(
   input  logic [31:7] instr,
   input  imm_type_t   imm_type,
   output logic [31:0] immediate
);

   always_comb begin
      immediate = '0;
      case (imm_type)
         IMM_I:   immediate = {{21{instr[31]}}, instr[30:20]};
         IMM_S:   immediate = {{21{instr[31]}}, instr[30:25], instr[11:7]};
         IMM_B:   immediate = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   immediate = {instr[31:12], 12'b0};
         IMM_J:   immediate = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: immediate = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/memory/writeback with
// combinational decode from the latched instruction and registered strobes.
module control_unit
   import alu_operations::*;
   import control_unit_types::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic           fetch_valid,
   input  logic           fetch_ready,
   input  logic [31:0]    fetch_instr,
   output logic           mem_valid,
   output logic           mem_write,
   input  logic           mem_ready,
   output alu_operation_t alu_operation,
   output src_1_sel_t     alu_src_1_sel,
   output src_2_sel_t     alu_src_2_sel,
   output logic [31:0]    immediate,
   output logic [4:0]     rs1_addr,
   output logic [4:0]     rs2_addr,
   output logic [4:0]     rd_addr,
   input  logic           alu_result_zero,
   input  logic           alu_result_lsb,
   output logic           rd_write_enable,
   output wb_sel_t        wb_sel,
   output logic           pc_write,
   output pc_sel_t        pc_sel,
   output logic           trap
);

   state_t      state;
   logic [31:0] instr_q;
   logic        taken_q;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   imm_type_t   imm_type;
   logic        writes_rd;
   logic        is_mem;
   logic        is_store;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic        illegal;
   logic        sys_trap;
   logic        rd_write_ok;
   logic        branch_cond;

   assign opcode   = instr_q[6:0];
   assign funct3   = instr_q[14:12];
   assign funct7   = instr_q[31:25];
   assign rd_addr  = instr_q[11:7];
   assign rs1_addr = instr_q[19:15];
   assign rs2_addr = instr_q[24:20];

   immediate_generator u_immediate_generator (
      .instr     (instr_q[31:7]),
      .imm_type  (imm_type),
      .immediate (immediate)
   );

   function automatic alu_operation_t arith_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? Subtract : Add;
         3'b001:  return Shift_Left_Logical;
         3'b010:  return Set_Less_Than;
         3'b011:  return Set_Less_Than_Unsigned;
         3'b100:  return Xor;
         3'b101:  return alt ? Shift_Right_Arithmetic : Shift_Right_Logical;
         3'b110:  return Or;
         default: return And;
      endcase
   endfunction

   always_comb begin
      alu_operation = Add;
      alu_src_1_sel = SRC1_RS1;
      alu_src_2_sel = SRC2_IMM;
      wb_sel        = WB_ALU;
      imm_type      = IMM_I;
      writes_rd     = 1'b0;
      is_mem        = 1'b0;
      is_store      = 1'b0;
      is_branch     = 1'b0;
      is_jal        = 1'b0;
      is_jalr       = 1'b0;
      illegal       = 1'b0;
      sys_trap      = 1'b0;
      case (opcode)
         OPC_OP: begin
            alu_operation = arith_op(funct3, funct7[5]);
            alu_src_2_sel = SRC2_RS2;
            writes_rd     = 1'b1;
            illegal       = !(funct7 == 7'h00 ||
                              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            // funct7[5] only selects SRAI; for ADDI/etc. those bits are immediate
            alu_operation = arith_op(funct3, funct3 == 3'b101 && funct7[5]);
            writes_rd     = 1'b1;
            illegal       = (funct3 == 3'b001 && funct7 != 7'h00) ||
                            (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
         end
         OPC_LOAD: begin
            wb_sel    = WB_MEM;
            writes_rd = 1'b1;
            is_mem    = 1'b1;
            illegal   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            imm_type = IMM_S;
            is_mem   = 1'b1;
            is_store = 1'b1;
            illegal  = funct3 > 3'b010;
         end
         OPC_BRANCH: begin
            alu_operation = funct3[2] ? (funct3[1] ? Set_Less_Than_Unsigned : Set_Less_Than)
                                      : Subtract;
            alu_src_2_sel = SRC2_RS2;
            imm_type      = IMM_B;
            is_branch     = 1'b1;
            illegal       = funct3[2:1] == 2'b01;
         end
         OPC_JAL: begin
            imm_type  = IMM_J;
            wb_sel    = WB_PC_PLUS_4;
            writes_rd = 1'b1;
            is_jal    = 1'b1;
         end
         OPC_JALR: begin
            wb_sel    = WB_PC_PLUS_4;
            writes_rd = 1'b1;
            is_jalr   = 1'b1;
         end
         OPC_LUI: begin
            alu_src_1_sel = SRC1_ZERO;
            imm_type      = IMM_U;
            writes_rd     = 1'b1;
         end
         OPC_AUIPC: begin
            alu_src_1_sel = SRC1_PC;
            imm_type      = IMM_U;
            writes_rd     = 1'b1;
         end
         OPC_MISC_MEM: ;
         OPC_SYSTEM: begin
            sys_trap = (instr_q == INSTR_ECALL) || (instr_q == INSTR_EBREAK);
            illegal  = !sys_trap;
         end
         default: illegal = 1'b1;
      endcase
      // An illegal word that is not halted on must behave as a plain NOP
      if (illegal) begin
         writes_rd = 1'b0;
         is_mem    = 1'b0;
         is_store  = 1'b0;
         is_branch = 1'b0;
         is_jal    = 1'b0;
         is_jalr   = 1'b0;
      end
   end

   assign rd_write_ok = writes_rd && (rd_addr != 5'd0);
   assign branch_cond = funct3[0] ^ (funct3[2] ? alu_result_lsb : alu_result_zero);

   always_comb begin
      pc_sel = PC_PLUS_4;
      if (is_jal || (is_branch && taken_q))
         pc_sel = PC_IMM;
      else if (is_jalr)
         pc_sel = PC_ALU_ALIGNED;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_FETCH;
         instr_q         <= '0;
         taken_q         <= 1'b0;
         fetch_valid     <= 1'b0;
         mem_valid       <= 1'b0;
         mem_write       <= 1'b0;
         rd_write_enable <= 1'b0;
         pc_write        <= 1'b0;
         trap            <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (fetch_valid && fetch_ready) begin
                  instr_q     <= fetch_instr;
                  fetch_valid <= 1'b0;
                  state       <= S_DECODE;
               end else begin
                  fetch_valid <= 1'b1;
               end
            end
            S_DECODE: begin
               taken_q <= 1'b0;
               if (sys_trap || (illegal && HALT_ON_ILLEGAL)) begin
                  trap  <= 1'b1;
                  state <= S_TRAP;
               end else begin
                  state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               taken_q <= is_branch && branch_cond;
               if (is_mem) begin
                  mem_valid <= 1'b1;
                  mem_write <= is_store;
                  state     <= S_MEMORY;
               end else begin
                  pc_write        <= 1'b1;
                  rd_write_enable <= rd_write_ok;
                  state           <= S_WRITEBACK;
               end
            end
            S_MEMORY: begin
               if (mem_ready) begin
                  mem_valid       <= 1'b0;
                  mem_write       <= 1'b0;
                  pc_write        <= 1'b1;
                  rd_write_enable <= rd_write_ok;
                  state           <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               pc_write        <= 1'b0;
               rd_write_enable <= 1'b0;
               fetch_valid     <= 1'b1;
               state           <= S_FETCH;
            end
            S_TRAP: trap <= 1'b1;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-computed expectations.
module tb_control_unit;
   import alu_operations::*;
   import control_unit_types::*;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           fetch_valid;
   logic           fetch_ready;
   logic [31:0]    fetch_instr;
   logic           mem_valid;
   logic           mem_write;
   logic           mem_ready;
   alu_operation_t alu_operation;
   src_1_sel_t     alu_src_1_sel;
   src_2_sel_t     alu_src_2_sel;
   logic [31:0]    immediate;
   logic [4:0]     rs1_addr;
   logic [4:0]     rs2_addr;
   logic [4:0]     rd_addr;
   logic           alu_result_zero;
   logic           alu_result_lsb;
   logic           rd_write_enable;
   wb_sel_t        wb_sel;
   logic           pc_write;
   pc_sel_t        pc_sel;
   logic           trap;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_instr     (fetch_instr),
      .mem_valid       (mem_valid),
      .mem_write       (mem_write),
      .mem_ready       (mem_ready),
      .alu_operation   (alu_operation),
      .alu_src_1_sel   (alu_src_1_sel),
      .alu_src_2_sel   (alu_src_2_sel),
      .immediate       (immediate),
      .rs1_addr        (rs1_addr),
      .rs2_addr        (rs2_addr),
      .rd_addr         (rd_addr),
      .alu_result_zero (alu_result_zero),
      .alu_result_lsb  (alu_result_lsb),
      .rd_write_enable (rd_write_enable),
      .wb_sel          (wb_sel),
      .pc_write        (pc_write),
      .pc_sel          (pc_sel),
      .trap            (trap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Waits (bounded) for fetch_valid, completes one handshake, returns in DECODE.
   task automatic do_fetch(input logic [31:0] ins);
      int unsigned waited = 0;
      while (fetch_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      check("fetch_valid_wait", 32'(fetch_valid), 32'd1);
      fetch_instr = ins;
      fetch_ready = 1'b1;
      step();
      fetch_ready = 1'b0;
   endtask

   initial begin
      logic quiet;
      rst_n           = 1'b0;
      fetch_ready     = 1'b0;
      fetch_instr     = '0;
      mem_ready       = 1'b0;
      alu_result_zero = 1'b0;
      alu_result_lsb  = 1'b0;
      step();
      check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      check("rst_mem_valid",   32'(mem_valid), 32'd0);
      check("rst_strobes",     32'({rd_write_enable, pc_write}), 32'd0);
      check("rst_trap",        32'(trap), 32'd0);
      check("rst_alu_op",      32'(alu_operation), 32'(Add));
      step();
      rst_n = 1'b1;
      step();
      check("fv_after_release", 32'(fetch_valid), 32'd1);

      // ADD x3,x1,x2
      do_fetch(32'h0020_81B3);
      check("add_op",   32'(alu_operation), 32'(Add));
      check("add_src1", 32'(alu_src_1_sel), 32'(SRC1_RS1));
      check("add_src2", 32'(alu_src_2_sel), 32'(SRC2_RS2));
      check("add_regs", {17'd0, rd_addr, rs1_addr, rs2_addr}, {17'd0, 5'd3, 5'd1, 5'd2});
      check("add_fv_low", 32'(fetch_valid), 32'd0);
      step();
      check("add_exec_strobes", 32'({rd_write_enable, pc_write}), 32'd0);
      step();
      check("add_wb_strobes", 32'({rd_write_enable, pc_write}), 32'b11);
      check("add_pc_sel", 32'(pc_sel), 32'(PC_PLUS_4));
      check("add_wb_sel", 32'(wb_sel), 32'(WB_ALU));
      step();
      check("add_next_fetch", 32'(fetch_valid), 32'd1);
      check("add_strobes_off", 32'({rd_write_enable, pc_write}), 32'd0);

      // SUB and SRAI
      do_fetch(32'h4020_81B3);
      check("sub_op", 32'(alu_operation), 32'(Subtract));
      repeat (3) step();
      do_fetch(32'h4032_D293);
      check("srai_op",   32'(alu_operation), 32'(Shift_Right_Arithmetic));
      check("srai_src2", 32'(alu_src_2_sel), 32'(SRC2_IMM));
      check("srai_shamt", 32'(immediate[4:0]), 32'd3);
      check("srai_rd",   32'(rd_addr), 32'd5);
      repeat (2) step();
      check("srai_rd_we", 32'(rd_write_enable), 32'd1);
      step();

      // BEQ x1,x2,+8 taken then not taken
      alu_result_zero = 1'b1;
      do_fetch(32'h0020_8463);
      check("beq_op",  32'(alu_operation), 32'(Subtract));
      check("beq_imm", immediate, 32'd8);
      repeat (2) step();
      check("beq_taken_pc_sel", 32'(pc_sel), 32'(PC_IMM));
      check("beq_taken_strobes", 32'({rd_write_enable, pc_write}), 32'b01);
      step();
      alu_result_zero = 1'b0;
      do_fetch(32'h0020_8463);
      repeat (2) step();
      check("beq_not_taken_pc_sel", 32'(pc_sel), 32'(PC_PLUS_4));
      check("beq_not_taken_rd_we", 32'(rd_write_enable), 32'd0);
      step();

      // LW x4,0(x1) with three wait cycles
      do_fetch(32'h0000_A203);
      check("lw_op", 32'(alu_operation), 32'(Add));
      check("lw_wb_sel", 32'(wb_sel), 32'(WB_MEM));
      step();
      check("lw_exec_mem_valid", 32'(mem_valid), 32'd0);
      for (int unsigned i = 0; i < 4; i++) begin
         step();
         check("lw_mem_valid", 32'({mem_valid, mem_write}), 32'b10);
         check("lw_no_early_strobe", 32'({rd_write_enable, pc_write}), 32'd0);
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("lw_mem_released", 32'(mem_valid), 32'd0);
      check("lw_wb_strobes", 32'({rd_write_enable, pc_write}), 32'b11);
      check("lw_rd", 32'(rd_addr), 32'd4);
      step();
      check("lw_single_pulse", 32'(rd_write_enable), 32'd0);

      // SW x2,0(x1): store writes no register
      do_fetch(32'h0020_A023);
      check("sw_imm", immediate, 32'd0);
      repeat (2) step();
      check("sw_mem", 32'({mem_valid, mem_write}), 32'b11);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("sw_wb_strobes", 32'({rd_write_enable, pc_write}), 32'b01);
      step();

      // JAL x1,+8
      do_fetch(32'h0080_00EF);
      check("jal_imm", immediate, 32'd8);
      check("jal_wb_sel", 32'(wb_sel), 32'(WB_PC_PLUS_4));
      repeat (2) step();
      check("jal_pc_sel", 32'(pc_sel), 32'(PC_IMM));
      check("jal_rd_we", 32'(rd_write_enable), 32'd1);
      step();

      // ADDI x0,x0,0 then an illegal word
      do_fetch(32'h0000_0013);
      repeat (2) step();
      check("nop_strobes", 32'({rd_write_enable, pc_write}), 32'b01);
      step();
      do_fetch(32'hFFFF_FFFF);
      step();
      check("illegal_trap", 32'(trap), 32'd1);
      quiet = 1'b1;
      fetch_ready = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         step();
         if (fetch_valid || mem_valid || pc_write || rd_write_enable || !trap) quiet = 1'b0;
      end
      fetch_ready = 1'b0;
      check("trap_sticky_quiet", 32'(quiet), 32'd1);

      // Reset while fetch_valid waits for fetch_ready
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (2) step();
      check("fv_waiting", 32'(fetch_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_fv", 32'(fetch_valid), 32'd0);
      check("async_rst_all", 32'({mem_valid, mem_write, rd_write_enable, pc_write, trap}), 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("fv_low_at_release", 32'(fetch_valid), 32'd0);
      step();
      check("fv_one_cycle_after", 32'(fetch_valid), 32'd1);

      // ECALL traps
      do_fetch(32'h0000_0073);
      check("ecall_no_trap_yet", 32'(trap), 32'd0);
      step();
      check("ecall_trap", 32'({trap, fetch_valid}), 32'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
